mc_decode: RTL and testbench
============================

// Module: mc_decode
// PURPOSE
//  Multicycle successor to the single-cycle ARM decoder: Moore FSM sequencing fetch, decode, execute,
//  memory and writeback phases, plus the ALU/flag decode from Op/Funct. Sits in the controller between
//  the instruction register and the datapath. Adds parametrised multiply latency, a two-write
//  long-multiply sequence and a separate base-register writeback cycle for pre-indexed memory ops.
// PARAMETERS
//  MUL_LAT  3  cycles an Op=11 multiply occupies the ALU before writeback (>=1)
//  ALUC_W   4  ALUControl width (ALU opcode table is 4-bit; wider values zero-extend)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  Op         in   2       instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 multiply
//  Funct      in   6       instr[25:20]; memory: [5]=~I,[3]=U,[1]=W(pre-index wb),[0]=L
//  Rd         in   4       destination register field
//  CondEx     in   1       condition passed, valid from DECODE onward
//  State      out  4       current FSM state (debug/trace)
//  IRWrite    out  1       load instruction register
//  AdrSrc     out  1       memory address: 0=PC, 1=ALU result
//  ALUSrcA    out  1       0=RegA, 1=PC
//  ALUSrcB    out  2       00=RegB, 01=ExtImm, 10=const 4
//  ResultSrc  out  2       00=ALUOut, 01=ReadData, 10=ALU result direct
//  PCWrite    out  1       PC load strobe
//  RegW       out  1       register-file write strobe (CondEx-gated)
//  Reg2W      out  1       write targets second destination (RdHi / base register)
//  MemW       out  1       data memory write strobe (CondEx-gated)
//  ALUControl out  ALUC_W  ALU opcode
//  FlagW      out  2       [1]=NZ write, [0]=CV write
//  Undef      out  1       one-cycle pulse: undefined encoding, instruction squashed
// BEHAVIOUR
//  - States: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXECR6 EXECI7 ALUWB8 BRANCH9 MULWAIT10
//    MULWB2_11 BASEWB12. State is the only register besides the mul counter; outputs are Moore decodes.
//  - reset low: State=FETCH, counter=0; IRWrite/PCWrite/RegW/MemW/Undef forced 0; other outputs take FETCH values.
//  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD(0000), PCWrite=1 -> DECODE.
//  - DECODE: ALUSrcA=1, ALUSrcB=10 (PC+8). Op=01->MEMADR; 00->EXECI if Funct[5] else EXECR; 10->BRANCH;
//    11->MULWAIT (MUL_LAT>1) else ALUWB; Op=11 with Funct[4:1]>1000 -> Undef=1, FETCH.
//  - MEMADR: ALUSrcB=01 (Funct[5]=0) or 00; ALUControl=ADD if U else SUB(0001); L->MEMRD, else MEMWR.
//  - MEMRD -> MEMWB (RegW, ResultSrc=01). MEMWR: AdrSrc=1, MemW=CondEx. Both then BASEWB if W else FETCH.
//  - BASEWB: RegW=CondEx, Reg2W=1, ResultSrc=00 (base <- computed address) -> FETCH.
//  - EXECR/EXECI: data-proc ALU table (ADD0000 SUB0001 AND0010 ORR0011 EOR0100 RSB0101; ADC/SBC/RSC carry
//    variants map to ADD/SUB/RSB); FlagW[1]=Funct[0], FlagW[0]=Funct[0] & ALUControl not in {0010,0011,0100};
//    compare ops (Funct[4:3]=10) -> FETCH without ALUWB, all others -> ALUWB.
//  - ALUWB: RegW=CondEx, ResultSrc=00; PCWrite=CondEx & (Rd==15). -> FETCH, or MULWB2 if long multiply.
//  - MULWAIT: counter counts 0..MUL_LAT-2 holding ALUControl (MUL0110, long0111, MLA1000, UMLAL1001) -> ALUWB.
//  - MULWB2: RegW=CondEx, Reg2W=1 (RdHi) -> FETCH. Long = Op=11 & Funct[4:1] in {0011,0100,0101,0110}.
//  - BRANCH: ALUSrcB=01, ALUControl=ADD, PCWrite=CondEx -> FETCH.
//  - FlagW=00 outside EXEC states. CondEx=0 suppresses strobes only; state path unchanged (fixed latency).
//  - Async reset mid-instruction (any state, incl. mid-MULWAIT) returns to FETCH; no partial write completes.
// CONFIGURATION
//  MC_DECODE_LONGMUL_EN defined: long multiplies use ALUWB + MULWB2 (two register writes).
//  Undefined: long-multiply encodings are undefined -> DECODE pulses Undef, returns to FETCH;
//    MULWB2 state unreachable, Reg2W asserted only in BASEWB.
// TESTING
//  1 ADD r1,r2,#5 (Op00,Funct=101000): FETCH,DECODE,EXECI,ALUWB; RegW=1 in ALUWB only; 4 cycles.
//  2 LDR pre-index W=1, U=0: MEMADR ALUControl=0001; MEMRD,MEMWB,BASEWB; Reg2W=1 only in BASEWB.
//  3 UMULL, MUL_LAT=3, LONGMUL_EN: DECODE, 2 MULWAIT cycles, ALUWB, MULWB2 (Reg2W=1); 6 cycles total.
//  4 CMP (Funct=10101,S=1), CondEx=1: FlagW=11 in EXECR, no ALUWB, back to FETCH; RegW never 1.
//  5 B with CondEx=0: BRANCH visited, PCWrite=0; STR with CondEx=0: MemW=0 in MEMWR.
//  6 reset low during MULWAIT: State=0 immediately (async); strobes 0; first post-reset cycle IRWrite=1.

Source files
------------

// File: rtl/mc_decode.sv
// Multicycle ARM controller: Moore FSM sequencing fetch/decode/execute/memory/writeback plus ALU/flag decode.
// Optional feature: MC_DECODE_LONGMUL_EN enables two-write long multiplies (ALUWB then MULWB2).
module mc_decode #(
  parameter int MUL_LAT = 3,
  parameter int ALUC_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic              CondEx,
  output logic [3:0]        State,
  output logic              IRWrite,
  output logic              AdrSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic              PCWrite,
  output logic              RegW,
  output logic              Reg2W,
  output logic              MemW,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [1:0]        FlagW,
  output logic              Undef
);

`ifdef MC_DECODE_LONGMUL_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int CNT_W      = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam int CNT_LAST_I = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_ORR   = 4'b0011;
  localparam logic [3:0] ALU_EOR   = 4'b0100;
  localparam logic [3:0] ALU_RSB   = 4'b0101;
  localparam logic [3:0] ALU_MUL   = 4'b0110;
  localparam logic [3:0] ALU_LMUL  = 4'b0111;
  localparam logic [3:0] ALU_MLA   = 4'b1000;
  localparam logic [3:0] ALU_UMLAL = 4'b1001;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_MULWAIT = 4'd10,
    S_MULWB2  = 4'd11,
    S_BASEWB  = 4'd12
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  logic       w_mul_long;
  logic       w_mul_undef;
  logic [3:0] w_mul_aluc;
  logic [3:0] w_dp_aluc;
  logic       w_dp_logic;
  logic       w_dp_cmp;
  logic       w_cnt_done;

  logic       w_irwrite;
  logic       w_adrsrc;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_resultsrc;
  logic       w_pcwrite;
  logic       w_regw;
  logic       w_reg2w;
  logic       w_memw;
  logic [3:0] w_aluc;
  logic [1:0] w_flagw;
  logic       w_undef;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Multiply latency counter: only advances while parked in MULWAIT, otherwise held at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == S_MULWAIT && !w_cnt_done) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_comb begin
    w_mul_long  = (Funct[4:1] == 4'b0011) || (Funct[4:1] == 4'b0100) ||
                  (Funct[4:1] == 4'b0101) || (Funct[4:1] == 4'b0110);
    w_mul_undef = (Funct[4:1] > 4'b1000) || (w_mul_long && !LONG_EN);
    if (w_mul_long) begin
      w_mul_aluc = (Funct[4:1] == 4'b0101) ? ALU_UMLAL : ALU_LMUL;
    end else if (Funct[4:1] == 4'b0001) begin
      w_mul_aluc = ALU_MLA;
    end else begin
      w_mul_aluc = ALU_MUL;
    end
  end

  // Carry variants share the plain adder/subtractor; compares share their arithmetic twin.
  always_comb begin
    w_dp_aluc = ALU_ADD;
    case (Funct[4:1])
      4'b0100, 4'b0101, 4'b1011: w_dp_aluc = ALU_ADD;
      4'b0010, 4'b0110, 4'b1010: w_dp_aluc = ALU_SUB;
      4'b0000, 4'b1000:          w_dp_aluc = ALU_AND;
      4'b1100:                   w_dp_aluc = ALU_ORR;
      4'b0001, 4'b1001:          w_dp_aluc = ALU_EOR;
      4'b0011, 4'b0111:          w_dp_aluc = ALU_RSB;
      default:                   w_dp_aluc = ALU_ADD;
    endcase
    w_dp_logic = (w_dp_aluc == ALU_AND) || (w_dp_aluc == ALU_ORR) || (w_dp_aluc == ALU_EOR);
    w_dp_cmp   = (Funct[4:3] == 2'b10);
  end

  always_comb begin
    w_next      = r_state;
    w_irwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_alusrca   = 1'b0;
    w_alusrcb   = 2'b00;
    w_resultsrc = 2'b00;
    w_pcwrite   = 1'b0;
    w_regw      = 1'b0;
    w_reg2w     = 1'b0;
    w_memw      = 1'b0;
    w_aluc      = ALU_ADD;
    w_flagw     = 2'b00;
    w_undef     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_pcwrite   = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        case (Op)
          2'b00: w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01: w_next = S_MEMADR;
          2'b10: w_next = S_BRANCH;
          default: begin
            if (w_mul_undef) begin
              w_undef = 1'b1;
              w_next  = S_FETCH;
            end else begin
              w_next = (MUL_LAT > 1) ? S_MULWAIT : S_ALUWB;
            end
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrcb = Funct[5] ? 2'b00 : 2'b01;
        w_aluc    = Funct[3] ? ALU_ADD : ALU_SUB;
        w_next    = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adrsrc = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        w_regw      = CondEx;
        w_resultsrc = 2'b01;
        w_next      = Funct[1] ? S_BASEWB : S_FETCH;
      end
      S_MEMWR: begin
        w_adrsrc = 1'b1;
        w_memw   = CondEx;
        w_next   = Funct[1] ? S_BASEWB : S_FETCH;
      end
      S_BASEWB: begin
        w_regw      = CondEx;
        w_reg2w     = 1'b1;
        w_resultsrc = 2'b00;
        w_next      = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        w_alusrcb = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        w_aluc    = w_dp_aluc;
        w_flagw   = {Funct[0], Funct[0] & ~w_dp_logic};
        w_next    = w_dp_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        w_regw      = CondEx;
        w_resultsrc = 2'b00;
        w_pcwrite   = CondEx & (Rd == 4'd15);
        if (Op == 2'b11) begin
          w_aluc = w_mul_aluc;
        end
        w_next = (Op == 2'b11 && w_mul_long && LONG_EN) ? S_MULWB2 : S_FETCH;
      end
      S_MULWAIT: begin
        w_aluc = w_mul_aluc;
        w_next = w_cnt_done ? S_ALUWB : S_MULWAIT;
      end
      S_MULWB2: begin
        w_regw  = CondEx;
        w_reg2w = 1'b1;
        w_aluc  = w_mul_aluc;
        w_next  = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrcb = 2'b01;
        w_pcwrite = CondEx;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are masked while reset is held so nothing fires out of the forced FETCH state.
  assign State      = r_state;
  assign IRWrite    = w_irwrite & reset;
  assign PCWrite    = w_pcwrite & reset;
  assign RegW       = w_regw & reset;
  assign MemW       = w_memw & reset;
  assign Undef      = w_undef & reset;
  assign Reg2W      = w_reg2w;
  assign AdrSrc     = w_adrsrc;
  assign ALUSrcA    = w_alusrca;
  assign ALUSrcB    = w_alusrcb;
  assign ResultSrc  = w_resultsrc;
  assign ALUControl = ALUC_W'(w_aluc);
  assign FlagW      = w_flagw;

endmodule

// File: tb/tb_mc_decode.sv
// Scoreboard bench for mc_decode: per-cycle expected control words queued at issue, popped at negedge.
module tb_mc_decode;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;
  logic [3:0] State;
  logic       IRWrite, AdrSrc, ALUSrcA, PCWrite, RegW, Reg2W, MemW, Undef;
  logic [1:0] ALUSrcB, ResultSrc, FlagW;
  logic [3:0] ALUControl;

  mc_decode #(.MUL_LAT(3), .ALUC_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx),
    .State(State), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .PCWrite(PCWrite), .RegW(RegW),
    .Reg2W(Reg2W), .MemW(MemW), .ALUControl(ALUControl), .FlagW(FlagW), .Undef(Undef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: [21:18] State [17:14] ALUControl [13:12] FlagW [11:10] ALUSrcB [9:8] ResultSrc
  //              [7] AdrSrc [6] ALUSrcA [5:0] {IRWrite,PCWrite,RegW,Reg2W,MemW,Undef}
  localparam logic [21:0] M_ST   = 22'h3C0000;
  localparam logic [21:0] M_ALUC = 22'h03C000;
  localparam logic [21:0] M_FW   = 22'h003000;
  localparam logic [21:0] M_SRCB = 22'h000C00;
  localparam logic [21:0] M_RES  = 22'h000300;
  localparam logic [21:0] M_ADR  = 22'h000080;
  localparam logic [21:0] M_SRCA = 22'h000040;
  localparam logic [21:0] M_STRB = 22'h00003F;
  localparam logic [21:0] M_BASE = M_ST | M_FW | M_STRB;
  localparam logic [21:0] M_ALL  = 22'h3FFFFF;

  typedef struct {
    string       tag;
    logic [21:0] exp;
    logic [21:0] mask;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  logic [1:0] p_op;
  logic [5:0] p_fn;
  logic [3:0] p_rd;
  logic       p_ce;

  function automatic logic [21:0] obs();
    return {State, ALUControl, FlagW, ALUSrcB, ResultSrc, AdrSrc, ALUSrcA,
            IRWrite, PCWrite, RegW, Reg2W, MemW, Undef};
  endfunction

  task automatic check_val(input string tag, input logic [21:0] got, input logic [21:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic px(input string tag, input logic [3:0] st, input logic [5:0] strb,
                    input logic [1:0] fw, input logic [3:0] aluc, input logic [1:0] srcb,
                    input logic [1:0] res, input logic adr, input logic srca,
                    input logic [21:0] xm);
    sb_t e;
    e.tag  = tag;
    e.exp  = {st, aluc, fw, srcb, res, adr, srca, strb};
    e.mask = M_BASE | xm;
    sb.push_back(e);
  endtask

  task automatic pf(input string tag);
    px(tag, 4'd0, 6'b110000, 2'b00, 4'b0000, 2'b10, 2'b10, 1'b0, 1'b1, M_ALL);
  endtask

  task automatic pd(input string tag, input logic undef);
    px(tag, 4'd1, {5'b00000, undef}, 2'b00, 4'b0000, 2'b10, 2'b00, 1'b0, 1'b1, M_SRCB | M_SRCA);
  endtask

  task automatic go(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd, input logic ce);
    p_op = op; p_fn = fn; p_rd = rd; p_ce = ce;
  endtask

  // One pop per clock at the negedge; the instruction fields are applied in the leading FETCH cycle.
  task automatic drain();
    sb_t e;
    int  i;
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      if (i == 0) begin
        Op = p_op; Funct = p_fn; Rd = p_rd; CondEx = p_ce;
      end
      #1;
      e = sb.pop_front();
      check_val(e.tag, obs() & e.mask, e.exp & e.mask);
      i++;
    end
  endtask

  task automatic check_now();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, obs() & e.mask, e.exp & e.mask);
    end
  endtask

  typedef struct {
    logic [5:0] fn;
    logic [3:0] aluc;
    logic [1:0] fw;
    logic       cmp;
  } dp_t;

  dp_t dp_tab[12] = '{
    '{6'b000101, 4'b0001, 2'b11, 1'b0},  // SUBS
    '{6'b000001, 4'b0010, 2'b10, 1'b0},  // ANDS
    '{6'b011001, 4'b0011, 2'b10, 1'b0},  // ORRS
    '{6'b000011, 4'b0100, 2'b10, 1'b0},  // EORS
    '{6'b000110, 4'b0101, 2'b00, 1'b0},  // RSB
    '{6'b001011, 4'b0000, 2'b11, 1'b0},  // ADCS
    '{6'b001100, 4'b0001, 2'b00, 1'b0},  // SBC
    '{6'b001111, 4'b0101, 2'b11, 1'b0},  // RSCS
    '{6'b010101, 4'b0001, 2'b11, 1'b1},  // CMP
    '{6'b010001, 4'b0010, 2'b10, 1'b1},  // TST
    '{6'b010111, 4'b0000, 2'b11, 1'b1},  // CMN
    '{6'b010011, 4'b0100, 2'b10, 1'b1}   // TEQ
  };

  task automatic mul_seq(input string tag, input logic [5:0] fn, input logic [3:0] aluc, input logic is_long);
    go(2'b11, fn, 4'd3, 1'b1);
    pf({tag, "_f"});
`ifdef MC_DECODE_LONGMUL_EN
    pd({tag, "_d"}, 1'b0);
    px({tag, "_w0"}, 4'd10, 6'b000000, 2'b00, aluc, 2'b00, 2'b00, 1'b0, 1'b0, M_ALUC);
    px({tag, "_w1"}, 4'd10, 6'b000000, 2'b00, aluc, 2'b00, 2'b00, 1'b0, 1'b0, M_ALUC);
    px({tag, "_wb"}, 4'd8, 6'b001000, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, M_RES);
    if (is_long) px({tag, "_wb2"}, 4'd11, 6'b001100, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 22'h0);
`else
    if (is_long) begin
      pd({tag, "_dundef"}, 1'b1);
    end else begin
      pd({tag, "_d"}, 1'b0);
      px({tag, "_w0"}, 4'd10, 6'b000000, 2'b00, aluc, 2'b00, 2'b00, 1'b0, 1'b0, M_ALUC);
      px({tag, "_w1"}, 4'd10, 6'b000000, 2'b00, aluc, 2'b00, 2'b00, 1'b0, 1'b0, M_ALUC);
      px({tag, "_wb"}, 4'd8, 6'b001000, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, M_RES);
    end
`endif
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b0;
    #3;
    px("reset_state", 4'd0, 6'b000000, 2'b00, 4'b0000, 2'b10, 2'b10, 1'b0, 1'b1, M_ALL);
    check_now();
    @(posedge clk); #2 reset = 1'b1;

    // ADD r1,r2,#5
    go(2'b00, 6'b101000, 4'd1, 1'b1);
    pf("addi_f"); pd("addi_d", 1'b0);
    px("addi_ex", 4'd7, 6'b000000, 2'b00, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0, M_ALUC | M_SRCB | M_SRCA);
    px("addi_wb", 4'd8, 6'b001000, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, M_RES);
    drain();

    foreach (dp_tab[k]) begin
      go(2'b00, dp_tab[k].fn, 4'd2, 1'b1);
      pf("dp_f"); pd("dp_d", 1'b0);
      px($sformatf("dp%0d_ex", k), 4'd6, 6'b000000, dp_tab[k].fw, dp_tab[k].aluc,
         2'b00, 2'b00, 1'b0, 1'b0, M_ALUC | M_SRCB | M_SRCA);
      if (!dp_tab[k].cmp)
        px($sformatf("dp%0d_wb", k), 4'd8, 6'b001000, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, M_RES);
      drain();
    end

    // ADD pc writes PC in ALUWB; same with CondEx=0 suppresses both strobes
    go(2'b00, 6'b101000, 4'd15, 1'b1);
    pf("addpc_f"); pd("addpc_d", 1'b0);
    px("addpc_ex", 4'd7, 6'b000000, 2'b00, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0, M_SRCB);
    px("addpc_wb", 4'd8, 6'b011000, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, M_RES);
    drain();
    go(2'b00, 6'b101000, 4'd15, 1'b0);
    pf("addnc_f"); pd("addnc_d", 1'b0);
    px("addnc_ex", 4'd7, 6'b000000, 2'b00, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0, 22'h0);
    px("addnc_wb", 4'd8, 6'b000000, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 22'h0);
    drain();

    // LDR pre-index, W=1 U=0
    go(2'b01, 6'b010011, 4'd4, 1'b1);
    pf("ldrw_f"); pd("ldrw_d", 1'b0);
    px("ldrw_adr", 4'd2, 6'b000000, 2'b00, 4'b0001, 2'b01, 2'b00, 1'b0, 1'b0, M_ALUC | M_SRCB | M_SRCA);
    px("ldrw_rd", 4'd3, 6'b000000, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, M_ADR);
    px("ldrw_wb", 4'd4, 6'b001000, 2'b00, 4'b0000, 2'b00, 2'b01, 1'b0, 1'b0, M_RES);
    px("ldrw_base", 4'd12, 6'b001100, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, M_RES);
    drain();

    // LDR register offset, U=1, no writeback
    go(2'b01, 6'b111001, 4'd4, 1'b1);
    pf("ldr_f"); pd("ldr_d", 1'b0);
    px("ldr_adr", 4'd2, 6'b000000, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, M_ALUC | M_SRCB);
    px("ldr_rd", 4'd3, 6'b000000, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, M_ADR);
    px("ldr_wb", 4'd4, 6'b001000, 2'b00, 4'b0000, 2'b00, 2'b01, 1'b0, 1'b0, M_RES);
    drain();

    // STR CondEx=1, then STR pre-index with CondEx=0
    go(2'b01, 6'b011000, 4'd5, 1'b1);
    pf("str_f"); pd("str_d", 1'b0);
    px("str_adr", 4'd2, 6'b000000, 2'b00, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0, M_ALUC | M_SRCB);
    px("str_wr", 4'd5, 6'b000010, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, M_ADR);
    drain();
    go(2'b01, 6'b011010, 4'd5, 1'b0);
    pf("strnc_f"); pd("strnc_d", 1'b0);
    px("strnc_adr", 4'd2, 6'b000000, 2'b00, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0, M_ALUC | M_SRCB);
    px("strnc_wr", 4'd5, 6'b000000, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, M_ADR);
    px("strnc_base", 4'd12, 6'b000100, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 22'h0);
    drain();

    // Branch not taken, then taken
    go(2'b10, 6'b100000, 4'd0, 1'b0);
    pf("bnc_f"); pd("bnc_d", 1'b0);
    px("bnc_br", 4'd9, 6'b000000, 2'b00, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0, M_ALUC | M_SRCB);
    drain();
    go(2'b10, 6'b100000, 4'd0, 1'b1);
    pf("b_f"); pd("b_d", 1'b0);
    px("b_br", 4'd9, 6'b010000, 2'b00, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0, M_ALUC | M_SRCB);
    drain();

    mul_seq("mul",   6'b000000, 4'b0110, 1'b0);
    mul_seq("mla",   6'b000010, 4'b1000, 1'b0);
    mul_seq("umull", 6'b001000, 4'b0111, 1'b1);
    mul_seq("umlal", 6'b001010, 4'b1001, 1'b1);

    // Op=11 encoding beyond the multiply table
    go(2'b11, 6'b010010, 4'd3, 1'b1);
    pf("und_f"); pd("und_d", 1'b1);
    drain();

    // Async reset during the second MULWAIT cycle
    go(2'b11, 6'b000000, 4'd3, 1'b1);
    pf("rmul_f"); pd("rmul_d", 1'b0);
    px("rmul_w0", 4'd10, 6'b000000, 2'b00, 4'b0110, 2'b00, 2'b00, 1'b0, 1'b0, M_ALUC);
    px("rmul_w1", 4'd10, 6'b000000, 2'b00, 4'b0110, 2'b00, 2'b00, 1'b0, 1'b0, M_ALUC);
    drain();
    #1 reset = 1'b0;
    #1;
    px("rmul_async", 4'd0, 6'b000000, 2'b00, 4'b0000, 2'b10, 2'b10, 1'b0, 1'b1, M_ALL);
    check_now();
    @(posedge clk); #2 reset = 1'b1;
    #1;
    pf("rmul_post");
    check_now();

    mul_seq("mul2", 6'b000000, 4'b0110, 1'b0);
    go(2'b00, 6'b000000, 4'd0, 1'b0);
    pf("idle_f");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
